// File: rtl/stopwatch_timekeeper.sv
// stopwatch_timekeeper
//
// Minutes/seconds timekeeping stage of the stopwatch. Counts on a 1 Hz tick
// while running, holds while paused, and lets the user step minutes or seconds
// on an adjust-rate tick while in adjust mode. All state is one registered
// stage: a tick sampled at a rising edge is visible on the outputs right after
// that edge.
//
// Ports:
//   clk_i          master clock, all state updates on its rising edge
//   rst_ni         synchronous active-low reset
//   tick_1hz_i     single-cycle 1 Hz count enable (used in run mode)
//   tick_adj_i     single-cycle adjust-rate enable (used in adjust mode)
//   clr_pulse_i    single-cycle clear request, zeroes both counters
//   pause_pulse_i  single-cycle pause toggle, honoured in every mode
//   sel_i          adjust target: 0 = minutes, 1 = seconds
//   adj_i          level, 1 = adjust mode
//   mincounter_o   registered minutes
//   seccounter_o   registered seconds
//   running_o      1 when in run mode (not adjusting, not paused)
//   wrap_o         registered single-cycle pulse on 59:59 -> 00:00 in run mode

module stopwatch_timekeeper #(
  parameter int unsigned CNT_W   = 6,
  parameter int unsigned MAX_VAL = 59
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_1hz_i,
  input  logic             tick_adj_i,
  input  logic             clr_pulse_i,
  input  logic             pause_pulse_i,
  input  logic             sel_i,
  input  logic             adj_i,
  output logic [CNT_W-1:0] mincounter_o,
  output logic [CNT_W-1:0] seccounter_o,
  output logic             running_o,
  output logic             wrap_o
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] ZeroCnt = '0;
  localparam logic [CNT_W-1:0] OneCnt = CNT_W'(1);

  // Mode is not stored: it is decoded from the adj level and the paused flag.
  typedef enum logic [1:0] {
    ModeRun    = 2'd0,
    ModePaused = 2'd1,
    ModeAdjust = 2'd2
  } mode_e;

  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] sec_q, sec_d;
  logic             paused_q, paused_d;
  logic             wrap_q, wrap_d;
  mode_e            mode;

  // Terminal-value detection shared by the run and adjust paths.
  logic sec_at_max;
  logic min_at_max;
  logic [CNT_W-1:0] sec_inc;
  logic [CNT_W-1:0] min_inc;

  assign sec_at_max = (sec_q == MaxCnt);
  assign min_at_max = (min_q == MaxCnt);
  assign sec_inc    = sec_at_max ? ZeroCnt : sec_q + OneCnt;
  assign min_inc    = min_at_max ? ZeroCnt : min_q + OneCnt;

  always_comb begin
    mode = ModeRun;
    if (adj_i) begin
      mode = ModeAdjust;
    end else if (paused_q) begin
      mode = ModePaused;
    end
  end

  always_comb begin
    min_d = min_q;
    sec_d = sec_q;
    wrap_d = 1'b0;
    // The pause toggle sits outside the clear/increment/hold priority chain.
    paused_d = paused_q ^ pause_pulse_i;

    if (clr_pulse_i) begin
      // Clear wins over any tick on the same edge.
      min_d = ZeroCnt;
      sec_d = ZeroCnt;
    end else begin
      unique case (mode)
        ModeRun: begin
          if (tick_1hz_i) begin
            sec_d = sec_inc;
            if (sec_at_max) begin
              min_d  = min_inc;
              wrap_d = min_at_max;
            end
          end
        end
        ModeAdjust: begin
          // Adjust steps one field only; seconds never carry into minutes.
          if (tick_adj_i) begin
            if (sel_i) begin
              sec_d = sec_inc;
            end else begin
              min_d = min_inc;
            end
          end
        end
        ModePaused: begin
          min_d = min_q;
          sec_d = sec_q;
        end
        default: begin
          min_d = min_q;
          sec_d = sec_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      min_q    <= ZeroCnt;
      sec_q    <= ZeroCnt;
      paused_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      min_q    <= min_d;
      sec_q    <= sec_d;
      paused_q <= paused_d;
      wrap_q   <= wrap_d;
    end
  end

  assign mincounter_o = min_q;
  assign seccounter_o = sec_q;
  assign wrap_o       = wrap_q;
  // Combinational from the live adj level so the display reacts at once.
  assign running_o    = ~adj_i & ~paused_q;

endmodule

// File: tb/tb_stopwatch_timekeeper.sv
module tb_stopwatch_timekeeper;

  localparam int CW = 6;
  localparam int MX = 59;
  localparam int N  = MX + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tick_1hz;
  logic          tick_adj;
  logic          clr_pulse;
  logic          pause_pulse;
  logic          sel;
  logic          adj;
  logic [CW-1:0] mincounter;
  logic [CW-1:0] seccounter;
  logic          running;
  logic          wrap;

  stopwatch_timekeeper #(
    .CNT_W   (CW),
    .MAX_VAL (MX)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .tick_1hz_i    (tick_1hz),
    .tick_adj_i    (tick_adj),
    .clr_pulse_i   (clr_pulse),
    .pause_pulse_i (pause_pulse),
    .sel_i         (sel),
    .adj_i         (adj),
    .mincounter_o  (mincounter),
    .seccounter_o  (seccounter),
    .running_o     (running),
    .wrap_o        (wrap)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int wrap_seen = 0;

  // Reference model: time as elapsed seconds modulo one hour.
  int m_min = 0;
  int m_sec = 0;
  int m_paused = 0;
  int m_wrap = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic t1, input logic ta, input logic clr, input logic pp);
    int total;
    if (!rst_n) begin
      m_min = 0; m_sec = 0; m_paused = 0; m_wrap = 0;
    end else begin
      m_wrap = 0;
      if (clr) begin
        m_min = 0; m_sec = 0;
      end else if (adj) begin
        if (ta) begin
          if (sel) m_sec = (m_sec + 1) % N;
          else     m_min = (m_min + 1) % N;
        end
      end else if (m_paused == 0 && t1) begin
        total  = (m_min * N + m_sec + 1) % (N * N);
        m_wrap = (total == 0) ? 1 : 0;
        m_min  = total / N;
        m_sec  = total % N;
      end
      if (pp) m_paused = 1 - m_paused;
    end
  endtask

  task automatic step(input logic t1, input logic ta, input logic clr, input logic pp);
    tick_1hz = t1; tick_adj = ta; clr_pulse = clr; pause_pulse = pp;
    @(posedge clk);
    model_edge(t1, ta, clr, pp);
    #1;
    if (wrap === 1'b1) wrap_seen++;
    check_eq("min", int'(mincounter), m_min);
    check_eq("sec", int'(seccounter), m_sec);
    check_eq("wrap", int'(wrap), m_wrap);
    check_eq("running", int'(running), (adj == 1'b0 && m_paused == 0) ? 1 : 0);
  endtask

  initial begin
    rst_n = 1'b0; adj = 1'b0; sel = 1'b0;
    tick_1hz = 1'b0; tick_adj = 1'b0; clr_pulse = 1'b0; pause_pulse = 1'b0;

    // 1: reset then 61 seconds
    step(0, 0, 0, 0);
    step(1, 1, 1, 1);
    check_eq("rst_min", int'(mincounter), 0);
    check_eq("rst_sec", int'(seccounter), 0);
    check_eq("rst_running", int'(running), 1);
    rst_n = 1'b1;
    wrap_seen = 0;
    repeat (61) begin
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
    end
    check_eq("t1_min", int'(mincounter), 1);
    check_eq("t1_sec", int'(seccounter), 1);
    check_eq("t1_nowrap", wrap_seen, 0);

    // 2: set 59:59 via adjust, then wrap
    adj = 1'b1; sel = 1'b0;
    repeat (58) step(0, 1, 0, 0);
    sel = 1'b1;
    repeat (58) step(0, 1, 0, 0);
    check_eq("t2_min59", int'(mincounter), 59);
    check_eq("t2_sec59", int'(seccounter), 59);
    adj = 1'b0;
    wrap_seen = 0;
    step(1, 0, 0, 0);
    check_eq("t2_wrap", int'(wrap), 1);
    check_eq("t2_zero", int'(mincounter) * 100 + int'(seccounter), 0);
    step(0, 0, 0, 0);
    check_eq("t2_wrap_drop", int'(wrap), 0);
    step(1, 0, 0, 0);
    check_eq("t2_sec1", int'(seccounter), 1);
    check_eq("t2_wrap_once", wrap_seen, 1);

    // 3: pause and clear
    repeat (9) step(1, 0, 0, 0);
    check_eq("t3_sec10", int'(seccounter), 10);
    step(0, 0, 0, 1);
    check_eq("t3_paused", int'(running), 0);
    repeat (5) step(1, 1, 0, 0);
    check_eq("t3_hold", int'(seccounter), 10);
    step(0, 0, 0, 1);
    check_eq("t3_resumed", int'(running), 1);
    step(1, 0, 0, 0);
    check_eq("t3_sec11", int'(seccounter), 11);
    step(1, 0, 1, 0);
    check_eq("t3_clr", int'(seccounter), 0);

    // 4: adjust 58:30 -> 01:30, then 01:58 -> 01:01
    adj = 1'b1; sel = 1'b0;
    repeat (58) step(0, 1, 0, 0);
    sel = 1'b1;
    repeat (30) step(0, 1, 0, 0);
    sel = 1'b0;
    repeat (3) step(1, 1, 0, 0);
    check_eq("t4_min1", int'(mincounter), 1);
    check_eq("t4_sec30", int'(seccounter), 30);
    sel = 1'b1;
    repeat (28) step(0, 1, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    check_eq("t4_min_nocarry", int'(mincounter), 1);
    check_eq("t4_sec1", int'(seccounter), 1);

    // 5: simultaneous events
    adj = 1'b0;
    step(1, 0, 1, 1);
    check_eq("t5_clr_min", int'(mincounter), 0);
    check_eq("t5_clr_sec", int'(seccounter), 0);
    check_eq("t5_clr_pause", int'(running), 0);
    step(0, 0, 0, 1);
    adj = 1'b1;
    step(0, 0, 0, 1);
    adj = 1'b0;
    step(0, 0, 0, 0);
    check_eq("t5_adj_pause", int'(running), 0);

    // 6: reset during adjust at 12:34 while paused
    adj = 1'b1; sel = 1'b0;
    repeat (12) step(0, 1, 0, 0);
    sel = 1'b1;
    repeat (34) step(0, 1, 0, 0);
    check_eq("t6_min12", int'(mincounter), 12);
    check_eq("t6_sec34", int'(seccounter), 34);
    rst_n = 1'b0;
    step(0, 1, 0, 0);
    rst_n = 1'b1;
    check_eq("t6_rst_min", int'(mincounter), 0);
    check_eq("t6_rst_sec", int'(seccounter), 0);
    adj = 1'b0;
    step(0, 0, 0, 0);
    check_eq("t6_running", int'(running), 1);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 49) == 0) adj = ~adj;
      sel = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 9) < 4),
           1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 99) < 4));
    end
    // Long uninterrupted run to exercise hour wrap from arbitrary state
    rst_n = 1'b1; adj = 1'b0;
    if (m_paused != 0) step(0, 0, 0, 1);
    repeat (3700) step(1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
